// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the D-cache bus master: response codes,
// byte-offset constant and the master FSM state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte-address bits below a 32-bit word.
    localparam int BYTE_OFF = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP,
        S_DONE
    } state_e;

endpackage

// File: rtl/axi_lite_wr_chan.sv
// AW/W issue tracker: both channels raise together on start and each valid
// drops independently the cycle after its own handshake.
module axi_lite_wr_chan #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                start_i,
    input  logic                active_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic [DATA_W/8-1:0] strb_i,
    input  logic                aw_ready_i,
    input  logic                w_ready_i,
    output logic                aw_valid_o,
    output logic [ADDR_W-1:0]   aw_addr_o,
    output logic                w_valid_o,
    output logic [DATA_W-1:0]   w_data_o,
    output logic [DATA_W/8-1:0] w_strb_o,
    output logic                both_done_o
);

    logic                aw_valid_q, aw_valid_d;
    logic                w_valid_q, w_valid_d;
    logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [DATA_W/8-1:0] w_strb_q, w_strb_d;

    always_comb begin
        aw_valid_d = aw_valid_q & ~aw_ready_i;
        w_valid_d  = w_valid_q & ~w_ready_i;
        aw_addr_d  = aw_addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        if (start_i) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_addr_d  = addr_i;
            w_data_d   = data_i;
            w_strb_d   = strb_i;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
        end else begin
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
        end
    end

    // Both channels retire on this edge (or already have).
    assign both_done_o = active_i & ~aw_valid_d & ~w_valid_d;

    assign aw_valid_o = aw_valid_q;
    assign aw_addr_o  = aw_addr_q;
    assign w_valid_o  = w_valid_q;
    assign w_data_o   = w_data_q;
    assign w_strb_o   = w_strb_q;

endmodule

// File: rtl/dcache_axi_lite_master.sv
// D-cache AXI4-Lite master: line refills become LINE_WORDS single-beat reads,
// stores become one strobed write; one transaction outstanding at a time.
module dcache_axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                refill_valid,
    output logic [IDX_W-1:0]    refill_idx,
    output logic [DATA_W-1:0]   refill_data,
    output logic                done,
    output logic                done_err,
    output logic                AW_VALID,
    input  logic                AW_READY,
    output logic [ADDR_W-1:0]   AW_ADDR,
    output logic                W_VALID,
    input  logic                W_READY,
    output logic [DATA_W-1:0]   W_DATA,
    output logic [DATA_W/8-1:0] W_STRB,
    input  logic                B_VALID,
    output logic                B_READY,
    input  logic [1:0]          B_RESP,
    output logic                AR_VALID,
    input  logic                AR_READY,
    output logic [ADDR_W-1:0]   AR_ADDR,
    input  logic                R_VALID,
    output logic                R_READY,
    input  logic [DATA_W-1:0]   R_DATA,
    input  logic [1:0]          R_RESP
);

    localparam int LINE_OFF = IDX_W + BYTE_OFF;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_OFF) - ADDR_W'(1));
    localparam logic [ADDR_W-1:0] WORD_MASK = ~((ADDR_W'(1) << BYTE_OFF) - ADDR_W'(1));
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
    logic                ar_valid_q, ar_valid_d;
    logic                r_ready_q, r_ready_d;
    logic                b_ready_q, b_ready_d;
    logic                rf_valid_q, rf_valid_d;
    logic [IDX_W-1:0]    rf_idx_q, rf_idx_d;
    logic [DATA_W-1:0]   rf_data_q, rf_data_d;
    logic                wr_start;
    logic                wr_both_done;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        base_d     = base_q;
        ar_addr_d  = ar_addr_q;
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;
        b_ready_d  = b_ready_q;
        rf_valid_d = 1'b0;
        rf_idx_d   = rf_idx_q;
        rf_data_d  = rf_data_q;
        wr_start   = 1'b0;
        cnt_inc    = cnt_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    err_d = 1'b0;
                    cnt_d = '0;
                    if (req_write) begin
                        wr_start = 1'b1;
                        state_d  = S_WR_REQ;
                    end else begin
                        base_d     = req_addr & LINE_MASK;
                        ar_addr_d  = req_addr & LINE_MASK;
                        ar_valid_d = 1'b1;
                        state_d    = S_RD_ADDR;
                    end
                end
            end
            S_RD_ADDR: begin
                if (AR_READY) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (R_VALID) begin
                    rf_valid_d = 1'b1;
                    rf_idx_d   = cnt_q;
                    rf_data_d  = R_DATA;
                    err_d      = err_q | (R_RESP != RESP_OKAY);
                    r_ready_d  = 1'b0;
                    // Error beats still fetch the whole line.
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d      = cnt_inc;
                        ar_valid_d = 1'b1;
                        ar_addr_d  = base_q + ({{(ADDR_W-IDX_W){1'b0}}, cnt_inc} << BYTE_OFF);
                        state_d    = S_RD_ADDR;
                    end
                end
            end
            S_WR_REQ: begin
                if (wr_both_done) begin
                    b_ready_d = 1'b1;
                    state_d   = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (B_VALID) begin
                    err_d     = err_q | (B_RESP != RESP_OKAY);
                    b_ready_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            base_q     <= '0;
            ar_addr_q  <= '0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            rf_valid_q <= 1'b0;
            rf_idx_q   <= '0;
            rf_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            base_q     <= base_d;
            ar_addr_q  <= ar_addr_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
            b_ready_q  <= b_ready_d;
            rf_valid_q <= rf_valid_d;
            rf_idx_q   <= rf_idx_d;
            rf_data_q  <= rf_data_d;
        end
    end

    axi_lite_wr_chan #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_chan (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .start_i     (wr_start),
        .active_i    (state_q == S_WR_REQ),
        .addr_i      (req_addr & WORD_MASK),
        .data_i      (req_wdata),
        .strb_i      (req_wstrb),
        .aw_ready_i  (AW_READY),
        .w_ready_i   (W_READY),
        .aw_valid_o  (AW_VALID),
        .aw_addr_o   (AW_ADDR),
        .w_valid_o   (W_VALID),
        .w_data_o    (W_DATA),
        .w_strb_o    (W_STRB),
        .both_done_o (wr_both_done)
    );

    assign req_ready    = (state_q == S_IDLE);
    assign done         = (state_q == S_DONE);
    assign done_err     = (state_q == S_DONE) & err_q;
    assign AR_VALID     = ar_valid_q;
    assign AR_ADDR      = ar_addr_q;
    assign R_READY      = r_ready_q;
    assign B_READY      = b_ready_q;
    assign refill_valid = rf_valid_q;
    assign refill_idx   = rf_idx_q;
    assign refill_data  = rf_data_q;

endmodule

// File: tb/tb_dcache_axi_lite_master.sv
// Bench for dcache_axi_lite_master: AXI4-Lite slave model with ready/error
// knobs, scoreboard queues for AR addresses, refill beats and done results.
module tb_dcache_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_WORDS = 4;
    localparam int IDX_W      = 2;
    localparam int STRB_W     = 4;
    localparam int W          = IDX_W + DATA_W;
    localparam int STORE_LAT  = 4;
    localparam int REFILL_LAT = 4 * LINE_WORDS + 1;

    logic              ACLK = 1'b0;
    logic              ARESETn = 1'b0;
    logic              req_valid = 1'b0, req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [STRB_W-1:0] req_wstrb = '0;
    logic              req_ready, refill_valid, done, done_err;
    logic [IDX_W-1:0]  refill_idx;
    logic [DATA_W-1:0] refill_data;
    logic              AW_VALID, W_VALID, B_READY, AR_VALID, R_READY;
    logic [ADDR_W-1:0] AW_ADDR, AR_ADDR;
    logic [DATA_W-1:0] W_DATA, R_DATA;
    logic [STRB_W-1:0] W_STRB;
    logic              B_VALID, R_VALID;
    logic [1:0]        B_RESP, R_RESP;
    logic              ar_ready_en = 1'b1, aw_ready_en = 1'b1, w_ready_en = 1'b1;
    logic              b_err_en = 1'b0;
    logic [ADDR_W-1:0] r_err_addr = '1;

    dcache_axi_lite_master dut (
        .ACLK (ACLK), .ARESETn (ARESETn),
        .req_valid (req_valid), .req_ready (req_ready), .req_write (req_write),
        .req_addr (req_addr), .req_wdata (req_wdata), .req_wstrb (req_wstrb),
        .refill_valid (refill_valid), .refill_idx (refill_idx), .refill_data (refill_data),
        .done (done), .done_err (done_err),
        .AW_VALID (AW_VALID), .AW_READY (aw_ready_en), .AW_ADDR (AW_ADDR),
        .W_VALID (W_VALID), .W_READY (w_ready_en), .W_DATA (W_DATA), .W_STRB (W_STRB),
        .B_VALID (B_VALID), .B_READY (B_READY), .B_RESP (B_RESP),
        .AR_VALID (AR_VALID), .AR_READY (ar_ready_en), .AR_ADDR (AR_ADDR),
        .R_VALID (R_VALID), .R_READY (R_READY), .R_DATA (R_DATA), .R_RESP (R_RESP)
    );

    // clock / reset
    always #5 ACLK = ~ACLK;
    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        for (int b = 0; b < 4; b++)
            if (strb[b]) old_w[8*b +: 8] = new_w[8*b +: 8];
        return old_w;
    endfunction

    // slave model: R_VALID two cycles after AR accept, B_VALID one cycle after AW+W
    logic [DATA_W-1:0] mem [0:255];
    logic [DATA_W-1:0] ref_mem [0:255];
    logic [ADDR_W-1:0] rd_addr_l, aw_addr_l;
    logic [DATA_W-1:0] w_data_l;
    logic [STRB_W-1:0] w_strb_l;
    logic              aw_got = 1'b0, w_got = 1'b0, b_wait = 1'b0;
    int                rd_wait = 0;
    wire               aw_fire = AW_VALID && aw_ready_en;
    wire               w_fire  = W_VALID && w_ready_en;
    wire               aw_have = aw_got || aw_fire;
    wire               w_have  = w_got || w_fire;
    wire [ADDR_W-1:0]  wa_eff  = aw_fire ? AW_ADDR : aw_addr_l;
    wire [DATA_W-1:0]  wd_eff  = w_fire ? W_DATA : w_data_l;
    wire [STRB_W-1:0]  ws_eff  = w_fire ? W_STRB : w_strb_l;

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            R_VALID <= 1'b0; R_DATA <= '0; R_RESP <= '0;
            B_VALID <= 1'b0; B_RESP <= '0;
            rd_wait <= 0; b_wait <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            if (R_VALID && R_READY) R_VALID <= 1'b0;
            if (AR_VALID && ar_ready_en) begin
                rd_addr_l <= AR_ADDR;
                rd_wait   <= 2;
            end else if (rd_wait == 2) begin
                rd_wait <= 1;
            end else if (rd_wait == 1) begin
                rd_wait <= 0;
                R_VALID <= 1'b1;
                R_DATA  <= mem[rd_addr_l[9:2]];
                R_RESP  <= (rd_addr_l == r_err_addr) ? RESP_SLVERR : RESP_OKAY;
            end
            if (B_VALID && B_READY) B_VALID <= 1'b0;
            if (aw_have && w_have) begin
                mem[wa_eff[9:2]] <= merge(mem[wa_eff[9:2]], wd_eff, ws_eff);
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                b_wait <= 1'b1;
            end else begin
                if (aw_fire) begin aw_got <= 1'b1; aw_addr_l <= AW_ADDR; end
                if (w_fire) begin w_got <= 1'b1; w_data_l <= W_DATA; w_strb_l <= W_STRB; end
            end
            if (b_wait) begin
                b_wait  <= 1'b0;
                B_VALID <= 1'b1;
                B_RESP  <= b_err_en ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // scoreboard
    logic [W-1:0]      exp_q[$];
    logic [ADDR_W-1:0] ar_q[$];
    logic [9:0]        done_exp_q[$];
    logic [9:0]        de;
    int                acc_cyc = 0;
    int                done_cnt = 0;
    int                rf_cnt = 0;

    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (AR_VALID && ar_ready_en) begin
                if (ar_q.size() == 0) check_eq("ar_extra", 1, 0);
                else check_eq("ar_addr", AR_ADDR, ar_q.pop_front());
            end
            if (refill_valid) begin
                rf_cnt++;
                if (exp_q.size() == 0) check_eq("refill_extra", 1, 0);
                else check_eq("refill", {refill_idx, refill_data}, exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                if (done_exp_q.size() == 0) begin
                    check_eq("done_extra", 1, 0);
                end else begin
                    de = done_exp_q.pop_front();
                    check_eq("done_err", done_err, de[0]);
                    if (de[9]) check_eq("latency", cyc - acc_cyc, de[8:1]);
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge ACLK);
        #2;
    endtask

    task automatic send_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic err, input logic chk_lat,
                            input logic partial);
        logic [31:0] base;
        int n;
        n = 0;
        while (!req_ready && n < 200) begin step(); n++; end
        check_eq("req_ready", req_ready, 1'b1);
        base = addr & 32'hFFFF_FFF0;
        if (wr) begin
            ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], wdata, strb);
            done_exp_q.push_back({chk_lat, 8'(STORE_LAT), err});
        end else begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                if (!partial || i < 2) ar_q.push_back(base + 32'(4 * i));
                if (!partial || i < 1) exp_q.push_back({IDX_W'(i), ref_mem[base[9:2] + 8'(i)]});
            end
            if (!partial) done_exp_q.push_back({chk_lat, 8'(REFILL_LAT), err});
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        acc_cyc = cyc;
        step();
        req_valid = 1'b0; req_write = 1'($urandom_range(0, 1));
        req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 400) begin step(); n++; end
        check_eq("done_count", done_cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n0, nd;
        logic        r_wr;
        logic [31:0] r_addr;
        nd = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[12] = 32'h11; mem[13] = 32'h22; mem[14] = 32'h33; mem[15] = 32'h44;
        mem[64] = 32'h0123_4567;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

        #1;
        check_eq("rst_valids", {AR_VALID, AW_VALID, W_VALID, B_READY, R_READY,
                                refill_valid, done, done_err}, 8'h00);
        check_eq("rst_addr", {AR_ADDR, AW_ADDR}, 64'h0);
        check_eq("rst_data", {W_DATA, W_STRB}, 36'h0);
        check_eq("rst_ready", req_ready, 1'b1);
        repeat (3) step();
        ARESETn = 1'b1;
        step();

        // line refill of 0x34 -> line 0x30
        send_req(1'b0, 32'h0000_0034, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0); nd++;
        wait_done(nd);

        // strobed store, then refill that line
        send_req(1'b1, 32'h0000_0102, 32'hDEAD_BEEF, 4'b1100, 1'b0, 1'b1, 1'b0); nd++;
        check_eq("st_aw_w", {AW_VALID, W_VALID, AW_ADDR}, {2'b11, 32'h100});
        check_eq("st_wdata", {W_DATA, W_STRB}, {32'hDEAD_BEEF, 4'b1100});
        wait_done(nd);
        send_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0); nd++;
        wait_done(nd);

        // W accepted before AW
        aw_ready_en = 1'b0;
        send_req(1'b1, 32'h0000_0208, 32'hCAFE_F00D, 4'b1111, 1'b0, 1'b0, 1'b0); nd++;
        step();
        check_eq("wfirst_w_drop", {AW_VALID, W_VALID, B_READY}, 3'b100);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("wfirst_hold", {AW_VALID, W_VALID, B_READY, AW_ADDR}, {3'b100, 32'h208});
        end
        aw_ready_en = 1'b1;
        step();
        check_eq("wfirst_bready", {AW_VALID, W_VALID, B_READY}, 3'b001);
        wait_done(nd);

        // error responses: read beat 2 and a store
        r_err_addr = 32'h0000_0038;
        send_req(1'b0, 32'h0000_0030, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0); nd++;
        wait_done(nd);
        r_err_addr = '1;
        b_err_en = 1'b1;
        send_req(1'b1, 32'h0000_0180, 32'h5555_AAAA, 4'b0011, 1'b1, 1'b1, 1'b0); nd++;
        wait_done(nd);
        b_err_en = 1'b0;
        send_req(1'b0, 32'h0000_0184, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0); nd++;
        wait_done(nd);

        // AR stall with a stray request pulse
        ar_ready_en = 1'b0;
        send_req(1'b0, 32'h0000_0088, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0); nd++;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_ar", {AR_VALID, AR_ADDR}, {1'b1, 32'h80});
            check_eq("stall_ready", req_ready, 1'b0);
            req_valid = (i == 1); req_write = 1'b1; req_addr = 32'h84;
            req_wdata = 32'hBAD0_BAD0; req_wstrb = 4'hF;
            step();
        end
        req_valid = 1'b0;
        ar_ready_en = 1'b1;
        wait_done(nd);

        // reset during beat 1 of a refill
        n0 = rf_cnt;
        send_req(1'b0, 32'h0000_0200, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (rf_cnt == n0 && n < 100) begin step(); n++; end
        n = 0;
        while (!R_READY && n < 100) begin step(); n++; end
        check_eq("abort_reach", R_READY, 1'b1);
        #1 ARESETn = 1'b0;
        #1 check_eq("abort_valids", {AR_VALID, AW_VALID, W_VALID, B_READY, R_READY,
                                     refill_valid, done}, 7'h00);
        step();
        step();
        check_eq("abort_no_done", done_cnt, nd);
        ARESETn = 1'b1;
        step();
        check_eq("abort_ready", req_ready, 1'b1);
        send_req(1'b0, 32'h0000_0200, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0); nd++;
        wait_done(nd);

        // random mix
        for (int k = 0; k < 8; k++) begin
            r_wr = 1'($urandom_range(0, 1));
            r_addr = 32'($urandom_range(0, 1023));
            send_req(r_wr, r_addr, $urandom, 4'($urandom_range(0, 15)), 1'b0, 1'b1, 1'b0); nd++;
            wait_done(nd);
        end

        step();
        check_eq("exp_q_left", exp_q.size(), 0);
        check_eq("ar_q_left", ar_q.size(), 0);
        check_eq("done_q_left", done_exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache_axi_lite_master.md
Name: dcache_axi_lite_master

Overview:
- AXI4-Lite master that turns D-cache miss/store requests into single-beat AXI4-Lite transactions.
- Pairs with the AXI4-Lite BRAM slave on the same bus.
- A line refill issues LINE_WORDS sequential reads and streams each word back to the cache. A store issues one word write with byte strobes.
- Only one AXI transaction is outstanding at any time. Sits between the D-cache controller and the bus.

Parameters:
DATA_W, 32, data width; W_STRB width is DATA_W/8
ADDR_W, 32, byte address width
LINE_WORDS, 4, words per cache line (power of 2, >=2)
IDX_W, $clog2(LINE_WORDS), refill word index width

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
req_valid  in  1  cache request valid
req_ready  out  1  block idle, request accepted when req_valid&&req_ready
req_write  in  1  1=word store, 0=line refill
req_addr  in  ADDR_W  byte address (refill: any byte in line; store: any byte in word)
req_wdata  in  DATA_W  store data
req_wstrb  in  DATA_W/8  store byte enables
refill_valid  out  1  one-cycle pulse per refilled word
refill_idx  out  IDX_W  word index within line
refill_data  out  DATA_W  refilled word
done  out  1  one-cycle pulse, request complete
done_err  out  1  valid with done; 1 if any RESP/BRESP != 2'b00
AW_VALID  out  1  / AW_READY in 1 / AW_ADDR out ADDR_W
W_VALID  out  1  / W_READY in 1 / W_DATA out DATA_W / W_STRB out DATA_W/8
B_VALID  in  1  / B_READY out 1 / B_RESP in 2
AR_VALID  out  1  / AR_READY in 1 / AR_ADDR out ADDR_W
R_VALID  in  1  / R_READY out 1 / R_DATA in DATA_W / R_RESP in 2

Behaviour:
- Reset (ARESETn low, async): state IDLE; word counter, error flag, AW_VALID, W_VALID, AR_VALID, B_READY, R_READY, refill_valid, done, done_err cleared to 0; all address/data outputs 0.
- Reset mid-transaction aborts immediately. No done pulse is produced and all valids drop.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- All AXI outputs are registered; no output combinationally depends on a READY/VALID input.
- req_ready = (state==IDLE), combinational from state.
- IDLE on request accept:
  - Latch req fields and clear the error flag.
  - Refill: base = req_addr with low log2(LINE_WORDS*4) bits cleared; go RD_ADDR with AR_VALID=1 and AR_ADDR=base the next cycle.
  - Store: go WR_REQ with AW_VALID=W_VALID=1, AW_ADDR = req_addr with low 2 bits cleared, W_DATA=req_wdata, W_STRB=req_wstrb.
- RD_ADDR: AR_VALID held stable until AR_READY. On handshake, drop AR_VALID, set R_READY=1, go RD_DATA.
- RD_DATA, on R_VALID&&R_READY:
  - Next cycle: refill_valid=1, refill_idx=counter, refill_data=R_DATA.
  - OR (R_RESP!=0) into the error flag; drop R_READY.
  - If counter==LINE_WORDS-1, go DONE. Otherwise increment counter, go RD_ADDR with AR_ADDR = base + 4*(counter+1).
  - Error beats do not abort the line; all LINE_WORDS beats are fetched.
- WR_REQ: AW_VALID and W_VALID are tracked independently. Each drops the cycle after its own handshake; address and data stay stable while valid.
  - If both complete in the same cycle (the normal case with our slave), both drop together.
  - When both are done, set B_READY=1 and go WR_RESP.
  - Either order of AW/W acceptance must work.
- WR_RESP: on B_VALID&&B_READY, record (B_RESP!=0), drop B_READY, go DONE.
- DONE (one cycle): done=1, done_err=error flag, then IDLE. A new request is accepted in the cycle after DONE.
- Latency against our BRAM slave, from request accept to done:
  - Store: 4 cycles.
  - Refill: 4*LINE_WORDS+1 cycles (AR accept, R_VALID two cycles later).
- Address wrap: base+4*i uses ADDR_W-bit arithmetic and never crosses the line, because base is line-aligned.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package axi_lite_pkg holds:
  - RESP codes OKAY=2'b00, SLVERR=2'b10.
  - FSM state encoding.
  - Byte-offset constant 2.
- One sub-module, axi_lite_wr_chan, is natural: it tracks the AW/W independent-valid handshake and reports both_done.

Test Plan:
- Refill req_addr=0x0000_0034, LINE_WORDS=4, slave words 0x11,0x22,0x33,0x44 at 0x30..0x3C -> AR_ADDR sequence 0x30,0x34,0x38,0x3C; refill_idx 0..3 with data 0x11..0x44; done=1, done_err=0 at cycle 17 after accept.
- Store req_addr=0x0000_0102, wdata=0xDEADBEEF, wstrb=4'b1100 -> AW_ADDR=0x100, W_STRB=4'b1100 in the same cycle; done at cycle 4, done_err=0; a subsequent refill of 0x100 returns word0 upper half 0xDEAD.
- Bus-functional slave accepts W 3 cycles before AW -> W_VALID drops after its handshake, AW_VALID stays high; B_READY asserts only after both complete; single done.
- Slave returns R_RESP=2'b10 on beat 2 and B_RESP=2'b10 on a store -> all 4 refill beats still delivered; done_err=1 for both requests.
- Hold AR_READY low for 5 cycles -> AR_VALID and AR_ADDR stable throughout; req_ready stays 0; a req_valid pulse during the stall is ignored.
- Assert ARESETn low during RD_DATA beat 1 -> all valids 0 asynchronously, no done; after release req_ready=1 and a new refill completes normally.
